// File: rtl/counter_bank_arbiter.sv
// Round-robin shared bank of counters: two valid/ready requesters issue read/add/load/clear.
// Response is registered one cycle after accept; ready equals grant and responses are never backpressured.
module counter_bank_arbiter #(
    parameter int WIDTH = 8,
    parameter int NCNT  = 4,
    parameter int IDXW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [1:0]            req0_op,
    input  logic [IDXW-1:0]       req0_idx,
    input  logic [WIDTH-1:0]      req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [1:0]            req1_op,
    input  logic [IDXW-1:0]       req1_idx,
    input  logic [WIDTH-1:0]      req1_data,
    output logic                  rsp_valid,
    output logic                  rsp_id,
    output logic [WIDTH-1:0]      rsp_value,
    output logic [NCNT*WIDTH-1:0] count_flat
);

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_ADD   = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    logic [WIDTH-1:0] cnt [NCNT];
    logic             last_grant;

    logic             gnt_vld;
    logic             gnt_id;
    op_t              sel_op;
    logic [IDXW-1:0]  sel_idx;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] new_value;

    // On a tie the requester that did not win last time gets the grant.
    assign gnt_vld    = req0_valid | req1_valid;
    assign gnt_id     = req1_valid & (~req0_valid | ~last_grant);
    assign req0_ready = req0_valid & ~gnt_id;
    assign req1_ready = req1_valid & gnt_id;

    always_comb begin
        sel_op   = gnt_id ? op_t'(req1_op) : op_t'(req0_op);
        sel_idx  = gnt_id ? req1_idx  : req0_idx;
        sel_data = gnt_id ? req1_data : req0_data;
        new_value = cnt[sel_idx];
        case (sel_op)
            OP_READ:  new_value = cnt[sel_idx];
            OP_ADD:   new_value = cnt[sel_idx] + sel_data;
            OP_LOAD:  new_value = sel_data;
            OP_CLEAR: new_value = '0;
            default:  new_value = cnt[sel_idx];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt[i] <= '0;
            end
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_value  <= '0;
        end else begin
            rsp_valid <= gnt_vld;
            if (gnt_vld) begin
                cnt[sel_idx] <= new_value;
                last_grant   <= gnt_id;
                rsp_id       <= gnt_id;
                rsp_value    <= new_value;
            end
        end
    end

    always_comb begin
        count_flat = '0;
        for (int i = 0; i < NCNT; i++) begin
            count_flat[i*WIDTH +: WIDTH] = cnt[i];
        end
    end

endmodule

// File: tb/tb_counter_bank_arbiter.sv
// Directed bench for counter_bank_arbiter: reset, add, round-robin, wrap, ordering, mid-flight reset.
module tb_counter_bank_arbiter;

    localparam int WIDTH = 8;
    localparam int NCNT  = 4;
    localparam int IDXW  = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req0_valid, req1_valid;
    logic                  req0_ready, req1_ready;
    logic [1:0]            req0_op, req1_op;
    logic [IDXW-1:0]       req0_idx, req1_idx;
    logic [WIDTH-1:0]      req0_data, req1_data;
    logic                  rsp_valid;
    logic                  rsp_id;
    logic [WIDTH-1:0]      rsp_value;
    logic [NCNT*WIDTH-1:0] count_flat;

    int checks = 0;
    int failures = 0;

    counter_bank_arbiter #(.WIDTH(WIDTH), .NCNT(NCNT), .IDXW(IDXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_idx(req0_idx), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_idx(req1_idx), .req1_data(req1_data),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_value(rsp_value),
        .count_flat(count_flat)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v0, input logic [1:0] o0, input logic [1:0] i0, input logic [7:0] d0,
                         input logic v1, input logic [1:0] o1, input logic [1:0] i1, input logic [7:0] d1);
        req0_valid = v0; req0_op = o0; req0_idx = i0; req0_data = d0;
        req1_valid = v1; req1_op = o1; req1_idx = i1; req1_data = d1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        drive(0, 2'b00, 2'd0, 8'd0, 0, 2'b00, 2'd0, 8'd0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if (count_flat !== 32'h0 || rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_value !== 8'h0) begin
            failures++;
            $display("FAIL reset_state: flat=%h vld=%b id=%b val=%h required 0/0/0/0",
                     count_flat, rsp_valid, rsp_id, rsp_value);
        end
        drive(1, 2'b00, 2'd0, 8'd0, 1, 2'b00, 2'd1, 8'd0);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_tie: rdy0=%b rdy1=%b required 1/0", req0_ready, req1_ready);
        end
        step();
        drive(0, 2'b00, 2'd0, 8'd0, 0, 2'b00, 2'd0, 8'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_value !== 8'h0) begin
            failures++;
            $display("FAIL reset_first_rsp: vld=%b id=%b val=%h required 1/0/00", rsp_valid, rsp_id, rsp_value);
        end
        step();
    endtask

    task automatic test_single_add;
        apply_reset();
        for (int k = 1; k <= 3; k++) begin
            drive(1, 2'b01, 2'd2, 8'd5, 0, 2'b00, 2'd0, 8'd0);
            #1;
            checks++;
            if (req0_ready !== 1'b1) begin
                failures++;
                $display("FAIL single_add_ready[%0d]: rdy0=%b required 1", k, req0_ready);
            end
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_value !== 8'(5 * k)) begin
                failures++;
                $display("FAIL single_add_rsp[%0d]: vld=%b id=%b val=%0d required 1/0/%0d",
                         k, rsp_valid, rsp_id, rsp_value, 5 * k);
            end
        end
        drive(0, 2'b00, 2'd0, 8'd0, 0, 2'b00, 2'd0, 8'd0);
        step();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_value !== 8'd15 || count_flat !== 32'h000F_0000) begin
            failures++;
            $display("FAIL single_add_idle: vld=%b val=%0d flat=%h required 0/15/000f0000",
                     rsp_valid, rsp_value, count_flat);
        end
    endtask

    task automatic test_round_robin;
        logic g;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            g = (i % 2) == 1;
            drive(1, 2'b01, 2'd0, 8'd1, 1, 2'b01, 2'd1, 8'd1);
            #1;
            checks++;
            if (req0_ready !== !g || req1_ready !== g) begin
                failures++;
                $display("FAIL rr_grant[%0d]: rdy0=%b rdy1=%b required %b/%b", i, req0_ready, req1_ready, !g, g);
            end
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== g) begin
                failures++;
                $display("FAIL rr_rsp_id[%0d]: vld=%b id=%b required 1/%b", i, rsp_valid, rsp_id, g);
            end
        end
        drive(0, 2'b00, 2'd0, 8'd0, 0, 2'b00, 2'd0, 8'd0);
        checks++;
        if (count_flat !== 32'h0000_0303) begin
            failures++;
            $display("FAIL rr_counts: flat=%h required 00000303", count_flat);
        end
    endtask

    task automatic test_wrap;
        apply_reset();
        drive(1, 2'b10, 2'd3, 8'hFE, 0, 2'b00, 2'd0, 8'd0);
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_value !== 8'hFE) begin
            failures++;
            $display("FAIL wrap_load: vld=%b val=%h required 1/fe", rsp_valid, rsp_value);
        end
        drive(1, 2'b01, 2'd3, 8'h03, 0, 2'b00, 2'd0, 8'd0);
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_value !== 8'h01 || count_flat !== 32'h0100_0000) begin
            failures++;
            $display("FAIL wrap_add: vld=%b val=%h flat=%h required 1/01/01000000",
                     rsp_valid, rsp_value, count_flat);
        end
        drive(0, 2'b00, 2'd0, 8'd0, 0, 2'b00, 2'd0, 8'd0);
        step();
    endtask

    task automatic test_back_to_back;
        apply_reset();
        drive(1, 2'b10, 2'd1, 8'd10, 0, 2'b00, 2'd0, 8'd0);
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_value !== 8'd10) begin
            failures++;
            $display("FAIL b2b_load: vld=%b id=%b val=%0d required 1/0/10", rsp_valid, rsp_id, rsp_value);
        end
        drive(0, 2'b11, 2'd2, 8'd99, 1, 2'b01, 2'd1, 8'd7);
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_value !== 8'd17) begin
            failures++;
            $display("FAIL b2b_add: vld=%b id=%b val=%0d required 1/1/17", rsp_valid, rsp_id, rsp_value);
        end
        drive(1, 2'b11, 2'd1, 8'd55, 0, 2'b00, 2'd0, 8'd0);
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_value !== 8'd0 || count_flat !== 32'h0) begin
            failures++;
            $display("FAIL b2b_clear: vld=%b id=%b val=%0d flat=%h required 1/0/0/00000000",
                     rsp_valid, rsp_id, rsp_value, count_flat);
        end
        drive(0, 2'b00, 2'd0, 8'd0, 0, 2'b00, 2'd0, 8'd0);
        step();
    endtask

    task automatic test_mid_reset;
        apply_reset();
        drive(1, 2'b01, 2'd0, 8'd9, 0, 2'b00, 2'd0, 8'd0);
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_accept: rdy0=%b required 1", req0_ready);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b0 || count_flat !== 32'h0) begin
            failures++;
            $display("FAIL midrst_in_reset: vld=%b flat=%h required 0/00000000", rsp_valid, count_flat);
        end
        drive(0, 2'b00, 2'd0, 8'd0, 0, 2'b00, 2'd0, 8'd0);
        rst_n = 1'b1;
        step();
        checks++;
        if (rsp_valid !== 1'b0 || count_flat !== 32'h0 || rsp_value !== 8'h0) begin
            failures++;
            $display("FAIL midrst_after: vld=%b flat=%h val=%h required 0/00000000/00",
                     rsp_valid, count_flat, rsp_value);
        end
    endtask

    initial begin
        drive(0, 2'b00, 2'd0, 8'd0, 0, 2'b00, 2'd0, 8'd0);
        test_reset();
        test_single_add();
        test_round_robin();
        test_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
